// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
// Shares one UDP transmit engine between two payload sources in the GMII TX
// clock domain. A grant is only issued while no ARP frame is pending. Each
// grant runs one packet: start pulse, byte steering, completion, then an
// inter-packet gap. A watchdog aborts a packet whose completion never comes.
//
// Optional build macro: UDP_TX_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, ch0 always wins a tie, no last-grant record
//   undefined -> round-robin, ch0 preferred first after reset
//
// Ports
//   clk, rst_n                  GMII TX clock, async active-low reset
//   arp_busy                    blocks new grants while high
//   ch0_req/ch1_req             level requests, held until chN_done
//   ch0_byte_num/ch1_byte_num   payload length, sampled at grant
//   ch0_data/ch1_data           payload byte, valid the cycle after data_req
//   ch0_data_req/ch1_data_req   udp_tx_req forwarded to the granted channel
//   ch0_done/ch1_done           one-cycle packet-end pulse
//   udp_tx_start_en             one-cycle engine start pulse
//   udp_tx_byte_num             registered length of the granted packet
//   udp_tx_data                 payload byte of the granted channel
//   udp_tx_req, udp_tx_done     engine byte request / completion
//   busy                        high whenever the FSM is not IDLE
//   tx_err                      one-cycle pulse on watchdog abort
module udp_tx_arbiter #(
  parameter int unsigned GAP_CYCLES  = 12,
  parameter logic [19:0] WDOG_CYCLES = 20'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_busy,
  input  logic        ch0_req,
  input  logic        ch1_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [15:0] ch1_byte_num,
  input  logic [7:0]  ch0_data,
  input  logic [7:0]  ch1_data,
  output logic        ch0_data_req,
  output logic        ch1_data_req,
  output logic        ch0_done,
  output logic        ch1_done,
  output logic        udp_tx_start_en,
  output logic [15:0] udp_tx_byte_num,
  output logic [7:0]  udp_tx_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        busy,
  output logic        tx_err
);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES);
  localparam logic [19:0] WDOG_LAST = WDOG_CYCLES - 20'd1;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;        // 0 = ch0, 1 = ch1
  logic [15:0] byte_num, byte_num_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [19:0] wdog, wdog_nxt;
  logic        done, done_nxt;
  logic        err_nxt;
  logic        win;
  logic [15:0] win_bytes;

`ifdef UDP_TX_ARB_FIXED_PRIO_EN
  assign win = ~ch0_req;
`else
  logic last, last_nxt;
  // On a tie the channel that was not served last wins.
  assign win = (ch0_req && ch1_req) ? ~last : ch1_req;
`endif

  assign win_bytes = win ? ch1_byte_num : ch0_byte_num;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    byte_num_nxt = byte_num;
    gap_cnt_nxt  = gap_cnt;
    wdog_nxt     = wdog;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifndef UDP_TX_ARB_FIXED_PRIO_EN
    last_nxt     = last;
`endif
    case (state)
      IDLE: begin
        if (!arp_busy && (ch0_req || ch1_req)) begin
          grant_nxt    = win;
          byte_num_nxt = win_bytes;
          gap_cnt_nxt  = 8'd0;
          if (win_bytes == 16'd0) begin
            // Nothing to send: complete immediately without touching the engine.
            done_nxt  = 1'b1;
            state_nxt = GAP;
`ifndef UDP_TX_ARB_FIXED_PRIO_EN
            last_nxt  = win;
`endif
          end else begin
            state_nxt = START;
          end
        end
      end
      START: begin
        wdog_nxt  = 20'd0;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (wdog != 20'hFFFFF) wdog_nxt = wdog + 20'd1;
        // Completion wins over a coincident watchdog expiry.
        if (udp_tx_done || wdog >= WDOG_LAST) begin
          done_nxt    = 1'b1;
          err_nxt     = ~udp_tx_done;
          gap_cnt_nxt = 8'd0;
          state_nxt   = GAP;
`ifndef UDP_TX_ARB_FIXED_PRIO_EN
          last_nxt    = grant;
`endif
        end
      end
      GAP: begin
        // First GAP cycle carries the done pulse; GAP_CYCLES idle cycles follow.
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 1'b0;
      byte_num <= 16'd0;
      gap_cnt  <= 8'd0;
      wdog     <= 20'd0;
      done     <= 1'b0;
      tx_err   <= 1'b0;
`ifndef UDP_TX_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      byte_num <= byte_num_nxt;
      gap_cnt  <= gap_cnt_nxt;
      wdog     <= wdog_nxt;
      done     <= done_nxt;
      tx_err   <= err_nxt;
`ifndef UDP_TX_ARB_FIXED_PRIO_EN
      last     <= last_nxt;
`endif
    end
  end

  assign busy            = (state != IDLE);
  assign udp_tx_start_en = (state == START);
  assign udp_tx_byte_num = byte_num;
  assign ch0_done        = done & ~grant;
  assign ch1_done        = done &  grant;
  assign ch0_data_req    = udp_tx_req & (state == BUSY) & ~grant;
  assign ch1_data_req    = udp_tx_req & (state == BUSY) &  grant;
  // Data can trail the last request by a cycle, so steer in every non-IDLE state.
  assign udp_tx_data     = (state == IDLE) ? 8'h00 : (grant ? ch1_data : ch0_data);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_busy = 1'b0;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [15:0] ch0_byte_num = 16'd0, ch1_byte_num = 16'd0;
  logic [7:0]  ch0_data = 8'h00, ch1_data = 8'h00;
  logic        ch0_data_req, ch1_data_req, ch0_done, ch1_done;
  logic        udp_tx_start_en, busy, tx_err;
  logic [15:0] udp_tx_byte_num;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_req = 1'b0, udp_tx_done = 1'b0;

  int vec = 0, miss = 0;
  int cyc = 0, starts = 0;
  bit ch1_req_seen = 1'b0;
  logic [7:0] src0 = 8'h00, src1 = 8'h80;

  udp_tx_arbiter #(.GAP_CYCLES(GAP), .WDOG_CYCLES(20'd64)) dut (
    .clk(clk), .rst_n(rst_n), .arp_busy(arp_busy),
    .ch0_req(ch0_req), .ch1_req(ch1_req),
    .ch0_byte_num(ch0_byte_num), .ch1_byte_num(ch1_byte_num),
    .ch0_data(ch0_data), .ch1_data(ch1_data),
    .ch0_data_req(ch0_data_req), .ch1_data_req(ch1_data_req),
    .ch0_done(ch0_done), .ch1_done(ch1_done),
    .udp_tx_start_en(udp_tx_start_en), .udp_tx_byte_num(udp_tx_byte_num),
    .udp_tx_data(udp_tx_data), .udp_tx_req(udp_tx_req), .udp_tx_done(udp_tx_done),
    .busy(busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // Payload sources: next byte appears the cycle after data_req.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (udp_tx_start_en) starts <= starts + 1;
    if (ch1_data_req) ch1_req_seen <= 1'b1;
    if (ch0_data_req) begin ch0_data <= src0; src0 <= src0 + 8'd1; end
    if (ch1_data_req) begin ch1_data <= src1; src1 <= src1 + 8'd1; end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (udp_tx_start_en === 1'b1) return;
      tick();
    end
    chk({tag, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) return;
      tick();
    end
    chk({tag, "_idle_timeout"}, 0, 1);
  endtask

  // Called in the START cycle: one byte request, then completion.
  task automatic finish_pkt(input string tag, input int ch);
    chk({tag, "_start"}, udp_tx_start_en, 1);
    tick();
    udp_tx_req = 1'b1; #1;
    chk({tag, "_dreq0"}, ch0_data_req, (ch == 0));
    chk({tag, "_dreq1"}, ch1_data_req, (ch == 1));
    tick();
    udp_tx_req = 1'b0; udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    chk({tag, "_done0"}, ch0_done, (ch == 0));
    chk({tag, "_done1"}, ch1_done, (ch == 1));
  endtask

  initial begin
    int t, tprev, k, n;
    bit hit;

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_start", udp_tx_start_en, 0);
    chk("rst_bytes", udp_tx_byte_num, 0);
    chk("rst_data", udp_tx_data, 0);
    chk("rst_done", {ch0_done, ch1_done, tx_err}, 0);
    tick(); rst_n = 1'b1; tick();

    // Completion pulse while IDLE is ignored
    udp_tx_done = 1'b1; tick(); udp_tx_done = 1'b0;
    chk("idle_done_ignored", {ch0_done, ch1_done, busy}, 0);

    // Single ch0 packet of 16 bytes
    ch0_req = 1'b1; ch0_byte_num = 16'd16;
    chk("t1_no_early_start", udp_tx_start_en, 0);
    tick();
    chk("t1_start", udp_tx_start_en, 1);
    chk("t1_bytes", udp_tx_byte_num, 16);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_once", udp_tx_start_en, 0);
    for (int i = 0; i < 16; i++) begin
      udp_tx_req = 1'b1; tick(); udp_tx_req = 1'b0;
      chk("t1_data", udp_tx_data, i);
    end
    udp_tx_done = 1'b1; tick(); udp_tx_done = 1'b0;
    ch0_req = 1'b0;
    chk("t1_done0", ch0_done, 1);
    chk("t1_done1", ch1_done, 0);
    tick();
    chk("t1_done_pulse", ch0_done, 0);
    wait_idle("t1");
    chk("t1_starts", starts, 1);
    chk("t1_ch1_dreq_never", ch1_req_seen, 0);
    chk("t1_idle_data", udp_tx_data, 0);
    chk("t1_bytes_held", udp_tx_byte_num, 16);

    // Both channels requesting, fresh from reset
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    ch0_req = 1'b1; ch1_req = 1'b1; ch0_byte_num = 16'd4; ch1_byte_num = 16'd4;
    tprev = 0;
    for (int p = 0; p < 4; p++) begin
      wait_start("rr");
      t = cyc;
      if (p > 0) chk("rr_spacing_ok", ((t - tprev) >= GAP + 2), 1);
      tprev = t;
`ifdef UDP_TX_ARB_FIXED_PRIO_EN
      finish_pkt("rr", 0);
`else
      finish_pkt("rr", p % 2);
`endif
    end
    ch0_req = 1'b0; ch1_req = 1'b0;
    wait_idle("rr");

    // ARP holds off the grant
    arp_busy = 1'b1; ch1_req = 1'b1; ch1_byte_num = 16'd4;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (udp_tx_start_en !== 1'b0) hit = 1'b1;
    end
    chk("arp_no_start", hit, 0);
    arp_busy = 1'b0;
    tick();
    finish_pkt("arp", 1);
    ch1_req = 1'b0;
    wait_idle("arp");

    // Zero-length request
    ch0_req = 1'b1; ch0_byte_num = 16'd0;
    tick();
    chk("zl_done0", ch0_done, 1);
    chk("zl_no_start", udp_tx_start_en, 0);
    chk("zl_busy", busy, 1);
    ch0_req = 1'b0;
    n = 1; hit = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (udp_tx_start_en !== 1'b0) hit = 1'b1;
      if (busy) n++;
    end
    chk("zl_busy_len", n, GAP + 1);
    chk("zl_no_start_gap", hit, 0);

    // Watchdog: engine never completes
    ch0_req = 1'b1; ch0_byte_num = 16'd8;
    wait_start("wd");
    tick();                                   // first BUSY cycle
    k = 0; hit = 1'b0;
    for (int i = 1; i <= 100 && !hit; i++) begin
      tick();
      if (tx_err === 1'b1) begin hit = 1'b1; k = i; end
    end
    chk("wd_err_cycle", k, 64);
    chk("wd_done0", ch0_done, 1);
    chk("wd_done1", ch1_done, 0);
    ch0_req = 1'b0;
    tick();
    chk("wd_err_pulse", tx_err, 0);
    ch1_req = 1'b1; ch1_byte_num = 16'd3;
    wait_start("wd_next");
    chk("wd_next_bytes", udp_tx_byte_num, 3);
    finish_pkt("wd_next", 1);
    ch1_req = 1'b0;
    wait_idle("wd");

    // Reset in the middle of BUSY
    ch0_req = 1'b1; ch0_byte_num = 16'd8;
    wait_start("rst");
    tick();
    udp_tx_req = 1'b1; #1;
    chk("rst_mid_dreq_before", ch0_data_req, 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dreq", {ch0_data_req, ch1_data_req}, 0);
    chk("rst_mid_bytes", udp_tx_byte_num, 0);
    chk("rst_mid_data", udp_tx_data, 0);
    chk("rst_mid_pulses", {udp_tx_start_en, ch0_done, ch1_done, tx_err}, 0);
    udp_tx_req = 1'b0; ch0_req = 1'b0; ch1_req = 1'b1; ch1_byte_num = 16'd5;
    tick(); rst_n = 1'b1;
    tick();
    chk("rst_ch1_grant_start", udp_tx_start_en, 1);
    chk("rst_ch1_bytes", udp_tx_byte_num, 5);
    finish_pkt("rst_ch1", 1);
    ch1_req = 1'b0; ch0_req = 1'b1; ch0_byte_num = 16'd2;
    wait_start("rst_ch0");
    finish_pkt("rst_ch0", 0);
    ch0_req = 1'b0;
    wait_idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
